keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_if.sv | 12 +
 rtl/keypad_scanner_tick.sv | 21 ++
 rtl/keypad_scanner.sv | 149 ++++++++++++++
 tb/tb_keypad_scanner.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state codes, key map, column drive constants and row-decode helpers
package keypad_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t SCAN     = 3'd1;
  localparam state_t DEBOUNCE = 3'd2;
  localparam state_t PRESSED  = 3'd3;
  localparam state_t RELEASE  = 3'd4;
  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // indexed {col, row}
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };
  function automatic logic single_low(input logic [3:0] r);
    return $countones(~r) == 1;
  endfunction
  function automatic logic [1:0] low_index(input logic [3:0] r);
    return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus decoded key outputs
//   enable, row (active-low rows) -> scanner; col, key_code, key_valid, key_held <- scanner
interface keypad_if;
  logic       enable;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  modport master (input enable, row, output col, key_code, key_valid, key_held);
  modport slave (output enable, row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_tick.sv
// scan_tick_gen: one-clock tick every CLK_HZ/SCAN_HZ clocks
//   clk, reset_n (async active-low) in; tick out
module scan_tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(TICK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, ghost rejection and hex key output
//   clk, reset_n (async active-low); kp: enable, row in; col, key_code, key_valid, key_held out
//   KEYPAD_REPEAT_EN: define to enable auto-repeat pulses while a key is held
module keypad_scanner #(
  parameter int CLK_HZ             = 100000000,
  parameter int SCAN_HZ            = 1000,
  parameter int DEBOUNCE_SCANS     = 4,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
) (
  input logic      clk,
  input logic      reset_n,
  keypad_if.master kp
);
  import keypad_pkg::*;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  logic       tick;
  logic [3:0] row_s1_q, row_s2_q;
  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d, cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d, key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic       single, cand_high, accept, released;
  logic [1:0] low_row;
  scan_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick)
  );
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] DELAY = 16'(REPEAT_DELAY_SCANS);
  localparam logic [15:0] RATE = 16'(REPEAT_RATE_SCANS);
  logic [15:0] rpt_q, rpt_d;
  logic        rpt_on_q, rpt_on_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY_SCANS, REPEAT_RATE_SCANS};
`endif
  always_comb begin
    single = single_low(row_s2_q);
    low_row = low_index(row_s2_q);
    cand_high = row_s2_q[cand_q];
    accept = kp.enable && tick && single &&
             ((state_q == SCAN && DEB == 4'd1) ||
              (state_q == DEBOUNCE && low_row == cand_q && cnt_q + 4'd1 == DEB));
    // a single-scan debounce releases straight from PRESSED
    released = kp.enable && tick && cand_high &&
               ((state_q == PRESSED && DEB == 4'd1) ||
                (state_q == RELEASE && cnt_q + 4'd1 == DEB));
    state_d = state_q;
    idx_d = idx_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    key_code_d = key_code_q;
    key_valid_d = 1'b0;
    key_held_d = key_held_q;
    if (!kp.enable) begin
      state_d = IDLE;
      key_held_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          idx_d = 2'd0;
        end
        SCAN: begin
          cand_d = low_row;
          cnt_d = 4'd1;
          state_d = single ? DEBOUNCE : SCAN;
          idx_d = single ? idx_q : idx_q + 2'd1;
        end
        DEBOUNCE: begin
          cnt_d = cnt_q + 4'd1;
          state_d = single && low_row == cand_q ? DEBOUNCE : SCAN;
          idx_d = single && low_row == cand_q ? idx_q : idx_q + 2'd1;
        end
        PRESSED: begin
          cnt_d = 4'd1;
          state_d = cand_high ? RELEASE : PRESSED;
        end
        RELEASE: begin
          cnt_d = cnt_q + 4'd1;
          state_d = cand_high ? RELEASE : PRESSED;
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        state_d = PRESSED;
        key_code_d = KEY_MAP[{idx_q, low_row}];
        key_valid_d = 1'b1;
        key_held_d = 1'b1;
      end
      if (released) begin
        state_d = SCAN;
        idx_d = idx_q + 2'd1;
        key_held_d = 1'b0;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    // counter only survives while staying in PRESSED, so any entry starts from zero
    rpt_d = state_q == PRESSED ? rpt_q : '0;
    rpt_on_d = state_q == PRESSED && rpt_on_q;
    if (kp.enable && tick && state_q == PRESSED && !cand_high) begin
      rpt_d = rpt_q + 16'd1;
      if (rpt_d == (rpt_on_q ? RATE : DELAY)) begin
        rpt_d = '0;
        rpt_on_d = 1'b1;
        key_valid_d = 1'b1;
      end
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      state_q <= IDLE;
      idx_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      key_code_q <= '0;
      key_valid_q <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
      state_q <= state_d;
      idx_q <= idx_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q <= key_held_d;
    end
`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rpt_q <= '0;
      rpt_on_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      rpt_on_q <= rpt_on_d;
    end
`endif
  assign kp.col = state_q == IDLE ? COL_IDLE : COL_DRIVE[idx_q];
  assign kp.key_code = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, ghost rejection, enable/reset and repeat
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] keys = '0;
  int cyc;
  int npulse = 0;
  int checks = 0;
  int errors = 0;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  keypad_if kp();
  keypad_scanner #(
    .CLK_HZ(1000),
    .SCAN_HZ(250),
    .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY_SCANS(5),
    .REPEAT_RATE_SCANS(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kp(kp.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk) if (kp.key_valid) npulse <= npulse + 1;
  // keys index {col, row}; a pressed key pulls its row low while its column is driven
  always_comb begin
    kp.row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !kp.col[c]) kp.row[r] = 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // tick edges fall every 4th clock after reset release; sample 1 time unit later
  task automatic wait_tick();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 4 != 0);
  endtask
  initial begin
    kp.enable = 1'b1;
    #1;
    check("rst_col", kp.col, 4'hF);
    check("rst_code", kp.key_code, 4'h0);
    check("rst_valid", kp.key_valid, 1'b0);
    check("rst_held", kp.key_held, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // 1: free scanning
    wait_tick(); check("scan0", kp.col, 4'b1110);
    wait_tick(); check("scan1", kp.col, 4'b1101);
    wait_tick(); check("scan2", kp.col, 4'b1011);
    wait_tick(); check("scan3", kp.col, 4'b0111);
    wait_tick(); check("scan_wrap", kp.col, 4'b1110);
    check("scan_nopulse", npulse, 0);
    // 2: key 6 (col2,row1)
    keys[2*4+1] = 1'b1;
    wait_tick();
    wait_tick(); check("k6_col", kp.col, 4'b1011);
    wait_tick(); check("k6_m1_held", kp.key_held, 1'b0);
    wait_tick(); check("k6_m2_valid", kp.key_valid, 1'b0);
    wait_tick();
    check("k6_valid", kp.key_valid, 1'b1);
    check("k6_code", kp.key_code, 4'h6);
    check("k6_held", kp.key_held, 1'b1);
    wait_tick();
    check("k6_one_pulse", kp.key_valid, 1'b0);
    wait_tick();
    check("k6_col_hold", kp.col, 4'b1011);
    keys[2*4+1] = 1'b0;
    wait_tick();
    wait_tick(); check("k6_rel2_held", kp.key_held, 1'b1);
    wait_tick();
    check("k6_rel3_held", kp.key_held, 1'b0);
    check("k6_rel_col", kp.col, 4'b0111);
    check("k6_npulse", npulse, 1);
    wait_tick(); check("k6_resume", kp.col, 4'b1110);
    // 3: bounce on key 1 (col0,row0)
    keys[0] = 1'b1;
    wait_tick();
    wait_tick(); check("bounce_hold_col", kp.col, 4'b1110);
    keys[0] = 1'b0;
    wait_tick();
    check("bounce_col", kp.col, 4'b1101);
    check("bounce_code", kp.key_code, 4'h6);
    check("bounce_npulse", npulse, 1);
    // 4: ghost, keys A and B in col3
    keys[3*4+0] = 1'b1;
    keys[3*4+1] = 1'b1;
    wait_tick();
    wait_tick(); check("ghost_col3", kp.col, 4'b0111);
    wait_tick(); check("ghost_skip", kp.col, 4'b1110);
    wait_tick();
    check("ghost_next", kp.col, 4'b1101);
    check("ghost_npulse", npulse, 1);
    keys[3*4+0] = 1'b0;
    keys[3*4+1] = 1'b0;
    wait_tick(); check("pre5_col", kp.col, 4'b1011);
    wait_tick();
    wait_tick(); check("pre5_col0", kp.col, 4'b1110);
    // 5a: key 7 (col0,row2), drop enable while pressed
    keys[0*4+2] = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    check("k7_valid", kp.key_valid, 1'b1);
    check("k7_code", kp.key_code, 4'h7);
    kp.enable = 1'b0;
    @(posedge clk);
    #1;
    check("dis_col", kp.col, 4'hF);
    check("dis_held", kp.key_held, 1'b0);
    check("dis_valid", kp.key_valid, 1'b0);
    check("dis_code", kp.key_code, 4'h7);
    wait_tick();
    wait_tick();
    check("dis_col_stay", kp.col, 4'hF);
    check("dis_npulse", npulse, 2);
    keys[0*4+2] = 1'b0;
    kp.enable = 1'b1;
    wait_tick(); check("reen_col", kp.col, 4'b1110);
    // 5b: reset mid-debounce on key 4 (col0,row1)
    keys[0*4+1] = 1'b1;
    wait_tick();
    wait_tick(); check("deb_col", kp.col, 4'b1110);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_col", kp.col, 4'hF);
    check("mid_rst_code", kp.key_code, 4'h0);
    check("mid_rst_held", kp.key_held, 1'b0);
    check("mid_rst_valid", kp.key_valid, 1'b0);
    keys[0*4+1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_tick();
    check("post_rst_col", kp.col, 4'b1110);
    check("post_rst_valid", kp.key_valid, 1'b0);
    check("post_rst_npulse", npulse, 2);
    // 6: key A (col3,row0) held, auto-repeat when built with it
    keys[3*4+0] = 1'b1;
    for (int i = 0; i < 5; i++) wait_tick();
    check("ka_pre_npulse", npulse, 2);
    wait_tick();
    check("ka_valid", kp.key_valid, 1'b1);
    check("ka_code", kp.key_code, 4'hA);
    check("ka_held", kp.key_held, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      wait_tick();
      check($sformatf("ka_rep%0d", i), kp.key_valid, REP && (i == 5 || i == 7 || i == 9));
      check($sformatf("ka_code%0d", i), kp.key_code, 4'hA);
    end
    wait_tick();
    check("ka_npulse", npulse, REP ? 6 : 3);
    keys = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
